// File: rtl/mux_sync_pkg.sv
// Shared types and constants for the mux-based clock-domain-crossing launcher
// and its receive-side companions.
package mux_sync_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SEND     = 2'd1,
      WAIT_LOW = 2'd2
   } state_e;

   localparam int XFER_CNT_W = 8;

endpackage

// File: rtl/bit_sync.sv
// N-stage single-bit synchroniser; bit N-1 of the chain is the synchronised output.
module bit_sync #(
   parameter int N = 2
) (
   input  logic clk,
   input  logic rstn,
   input  logic d,
   output logic q
);

   logic [N-1:0] sync_q;
   logic [N-1:0] sync_d;

   always_comb begin
      sync_d = {sync_q[N-2:0], d};
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) sync_q <= '0;
      else       sync_q <= sync_d;
   end

   assign q = sync_q[N-1];

endmodule

// File: rtl/mux_sync_tx.sv
// Source-side launcher: holds a word on data_out with a level enable and runs a
// four-phase handshake against the synchronised acknowledge from the far domain.
module mux_sync_tx
   import mux_sync_pkg::*;
#(
   parameter int DW              = 4,
   parameter int ACK_SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic [DW-1:0]         in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [DW-1:0]         data_out,
   output logic                  data_en,
   input  logic                  ack,
   output logic                  done,
   output logic [XFER_CNT_W-1:0] xfer_cnt,
   output logic                  ack_err
);

   logic                  ack_s;
   state_e                state_q,  state_d;
   logic [DW-1:0]         data_q,   data_d;
   logic                  en_q,     en_d;
   logic                  done_q,   done_d;
   logic [XFER_CNT_W-1:0] cnt_q,    cnt_d;
   logic                  err_q,    err_d;

   bit_sync #(.N(ACK_SYNC_STAGES)) u_ack_sync (
      .clk  (clk),
      .rstn (rstn),
      .d    (ack),
      .q    (ack_s)
   );

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      en_d    = en_q;
      done_d  = 1'b0;
      cnt_d   = cnt_q;
      // An ack seen while idle is a protocol violation; flag it but keep going.
      err_d   = err_q | ((state_q == IDLE) & ack_s);
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               data_d  = in_data;
               en_d    = 1'b1;
               state_d = SEND;
            end
         end
         SEND: begin
            if (ack_s) begin
               en_d    = 1'b0;
               state_d = WAIT_LOW;
            end
         end
         WAIT_LOW: begin
            if (!ack_s) begin
               done_d  = 1'b1;
               cnt_d   = cnt_q + XFER_CNT_W'(1);
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
         data_q  <= '0;
         en_q    <= 1'b0;
         done_q  <= 1'b0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         en_q    <= en_d;
         done_q  <= done_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   assign in_ready = (state_q == IDLE);
   assign data_out = data_q;
   assign data_en  = en_q;
   assign done     = done_q;
   assign xfer_cnt = cnt_q;
   assign ack_err  = err_q;

endmodule

// File: tb/tb_mux_sync_tx.sv
// Directed bench for mux_sync_tx: handshake timing, back-to-back, spurious ack,
// mid-transfer reset and counter wrap.
module tb_mux_sync_tx;

   localparam int DW = 4;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic [DW-1:0] in_data = '0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [DW-1:0] data_out;
   logic          data_en;
   wire           ack;
   logic          done;
   logic [7:0]    xfer_cnt;
   logic          ack_err;

   logic man_ack  = 1'b0;
   logic resp_ack = 1'b0;
   logic resp_en  = 1'b0;
   assign ack = man_ack | resp_ack;

   int checks = 0;
   int errors = 0;

   mux_sync_tx #(.DW(DW), .ACK_SYNC_STAGES(2)) dut (
      .clk      (clk),
      .rstn     (rstn),
      .in_data  (in_data),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .data_out (data_out),
      .data_en  (data_en),
      .ack      (ack),
      .done     (done),
      .xfer_cnt (xfer_cnt),
      .ack_err  (ack_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Destination model: raise ack 3 cycles after data_en, drop it 3 cycles after data_en falls.
   int r_hi = 0, r_lo = 0;
   always @(negedge clk) begin
      if (!resp_en || !rstn) begin
         resp_ack = 1'b0; r_hi = 0; r_lo = 0;
      end else if (data_en && !resp_ack) begin
         r_hi++;
         if (r_hi == 3) begin resp_ack = 1'b1; r_hi = 0; end
      end else if (!data_en && resp_ack) begin
         r_lo++;
         if (r_lo == 3) begin resp_ack = 1'b0; r_lo = 0; end
      end
   end

   // Completion log and data-stability watch.
   int            done_cnt = 0;
   int            stab_bad = 0;
   logic [DW-1:0] seen[$];
   logic          prev_en = 1'b0;
   logic [DW-1:0] prev_d = '0;
   always @(negedge clk) begin
      if (done) begin
         done_cnt++;
         seen.push_back(data_out);
      end
      if (prev_en && data_en && data_out !== prev_d) stab_bad++;
      prev_en = data_en;
      prev_d  = data_out;
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send(input logic [DW-1:0] w, input bit hold);
      in_data  = w;
      in_valid = 1'b1;
      for (int i = 0; i < 400; i++) begin
         if (in_ready) begin
            @(negedge clk);
            if (!hold) in_valid = 1'b0;
            return;
         end
         @(negedge clk);
      end
      chk("accept_timeout", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b0;
   endtask

   task automatic wait_done(input int target, input int budget);
      for (int i = 0; i < budget && done_cnt < target; i++) @(negedge clk);
      chk("done_count", done_cnt, target);
   endtask

   int base;

   initial begin
      // Reset and idle
      cyc(3);
      chk("rst_en", {31'd0, data_en}, 0);
      chk("rst_rdy", {31'd0, in_ready}, 1);
      rstn = 1'b1;
      cyc(1);
      chk("rst_data", {28'd0, data_out}, 0);
      chk("rst_done", {31'd0, done}, 0);
      chk("rst_cnt", {24'd0, xfer_cnt}, 0);
      chk("rst_err", {31'd0, ack_err}, 0);
      cyc(20);
      chk("idle_en", {31'd0, data_en}, 0);
      chk("idle_rdy", {31'd0, in_ready}, 1);
      chk("idle_cnt", {24'd0, xfer_cnt}, 0);

      // Single transfer with hand-timed ack
      send(4'hA, 1'b0);
      chk("acc_data", {28'd0, data_out}, 32'hA);
      chk("acc_en", {31'd0, data_en}, 1);
      chk("acc_rdy", {31'd0, in_ready}, 0);
      cyc(4);
      man_ack = 1'b1;
      cyc(2);
      chk("en_hold2", {31'd0, data_en}, 1);
      cyc(1);
      chk("en_fall3", {31'd0, data_en}, 0);
      chk("wl_rdy", {31'd0, in_ready}, 0);
      man_ack = 1'b0;
      cyc(2);
      chk("done_early", {31'd0, done}, 0);
      cyc(1);
      chk("done_pulse", {31'd0, done}, 1);
      chk("done_rdy", {31'd0, in_ready}, 1);
      chk("cnt1", {24'd0, xfer_cnt}, 1);
      cyc(1);
      chk("done_one", {31'd0, done}, 0);

      // Back-to-back with responder
      base = done_cnt;
      resp_en = 1'b1;
      send(4'h1, 1'b1);
      send(4'h2, 1'b1);
      send(4'h3, 1'b0);
      wait_done(base + 3, 500);
      for (int i = 0; i < 3; i++) chk("b2b_word", {28'd0, seen[base + i]}, i + 1);
      chk("cnt4", {24'd0, xfer_cnt}, 4);

      // Spurious ack in idle
      resp_en = 1'b0;
      cyc(2);
      man_ack = 1'b1;
      cyc(4);
      man_ack = 1'b0;
      cyc(4);
      chk("sp_err", {31'd0, ack_err}, 1);
      chk("sp_en", {31'd0, data_en}, 0);
      chk("sp_cnt", {24'd0, xfer_cnt}, 4);
      resp_en = 1'b1;
      base = done_cnt;
      send(4'h5, 1'b0);
      wait_done(base + 1, 500);
      chk("sp_word", {28'd0, seen[base]}, 5);
      chk("sp_err_sticky", {31'd0, ack_err}, 1);
      chk("cnt5", {24'd0, xfer_cnt}, 5);

      // Reset mid-transfer while in SEND
      resp_en = 1'b0;
      cyc(2);
      base = done_cnt;
      send(4'hC, 1'b0);
      chk("mid_data", {28'd0, data_out}, 32'hC);
      cyc(2);
      rstn = 1'b0;
      #1;
      chk("mr_en", {31'd0, data_en}, 0);
      chk("mr_data", {28'd0, data_out}, 0);
      chk("mr_rdy", {31'd0, in_ready}, 1);
      chk("mr_cnt", {24'd0, xfer_cnt}, 0);
      chk("mr_err", {31'd0, ack_err}, 0);
      cyc(3);
      rstn = 1'b1;
      cyc(3);
      chk("mr_no_done", done_cnt, base);

      // Counter wrap over 256 transfers
      resp_en = 1'b1;
      base = done_cnt;
      for (int i = 0; i < 255; i++) send(4'(i), i != 254);
      wait_done(base + 255, 5000);
      chk("cnt255", {24'd0, xfer_cnt}, 255);
      send(4'hF, 1'b0);
      wait_done(base + 256, 500);
      chk("cnt_wrap", {24'd0, xfer_cnt}, 0);
      chk("wrap_w128", {28'd0, seen[base + 128]}, 0);
      chk("wrap_w255", {28'd0, seen[base + 255]}, 32'hF);
      cyc(5);
      chk("wrap_total", done_cnt - base, 256);
      chk("stable", stab_bad, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
